// File: rtl/pe_pending_encoder.sv
// Round-robin pending-set encoder: accumulates multi-hot lane flags and emits
// them one at a time as binary lane indices over a valid/ready stream.
module pe_pending_encoder #(
    parameter  int ADDR_WIDTH = 3,
    localparam int N          = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [N-1:0]          set_vec,
    input  logic                  clr_all,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [N-1:0]          pending,
    output logic                  busy,
    output logic                  overflow
);

    logic [N-1:0]          pending_q;
    logic [N-1:0]          pending_d;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [ADDR_WIDTH-1:0] rr_ptr_q;
    logic                  overflow_q;
    logic                  overflow_d;

    logic                  slot_free;
    logic [2*N-1:0]        doubled;
    logic [N-1:0]          rotated;
    logic                  found;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] grant_idx;
    logic                  grant;
    logic [N-1:0]          grant_mask;
    logic [N-1:0]          set_bits;

    assign slot_free = !out_valid_q || out_ready;

    // Rotate pending so that rr_ptr lands at bit 0; the first set bit of the
    // rotated vector is the distance from rr_ptr to the winning lane.
    always_comb begin
        doubled = {pending_q, pending_q} >> rr_ptr_q;
        rotated = doubled[N-1:0];
        found   = 1'b0;
        offset  = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rotated[i]) begin
                found  = 1'b1;
                offset = i[ADDR_WIDTH-1:0];
            end
        end
    end

    assign grant_idx  = rr_ptr_q + offset;
    assign grant      = slot_free && found;
    assign grant_mask = grant ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign set_bits   = set_en ? set_vec : '0;

    // A set landing on the lane being granted re-arms it rather than overflowing.
    assign pending_d  = (pending_q & ~grant_mask) | set_bits;
    assign overflow_d = |(set_bits & pending_q & ~grant_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            rr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else if (clr_all) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            if (grant) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= grant_idx;
                rr_ptr_q    <= grant_idx + 1'b1;
            end else if (slot_free) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign pending   = pending_q;
    assign busy      = (|pending_q) || out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pe_pending_encoder.sv
// Directed bench for pe_pending_encoder: a lane-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_pe_pending_encoder;

    localparam int AW = 3;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          set_en = 1'b0;
    logic [N-1:0]  set_vec = '0;
    logic          clr_all = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [N-1:0]  pending;
    logic          busy;
    logic          overflow;

    int tests_run = 0;
    int tests_failed = 0;

    pe_pending_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .set_en(set_en),
        .set_vec(set_vec),
        .clr_all(clr_all),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr(out_addr),
        .pending(pending),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: lanes as a bit set, pointer as an integer, searched in
    // plain modular order from the round-robin pointer.
    bit [N-1:0] m_pending;
    bit         m_valid;
    int         m_addr;
    int         m_rr;
    bit         m_ovf;

    always @(posedge clk or negedge rst_n) begin
        bit [N-1:0] np;
        bit         free;
        int         g;
        if (!rst_n) begin
            m_pending <= '0;
            m_valid   <= 1'b0;
            m_addr    <= 0;
            m_rr      <= 0;
            m_ovf     <= 1'b0;
        end else if (clr_all) begin
            m_pending <= '0;
            m_valid   <= 1'b0;
            m_rr      <= 0;
            m_ovf     <= 1'b0;
        end else begin
            free = !m_valid || out_ready;
            g = -1;
            if (free) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && m_pending[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
            end
            np = m_pending;
            if (g >= 0) np[g] = 1'b0;
            m_ovf <= set_en && ((set_vec & np) != 0);
            if (set_en) np = np | set_vec;
            m_pending <= np;
            if (g >= 0) begin
                m_valid <= 1'b1;
                m_addr  <= g;
                m_rr    <= (g + 1) % N;
            end else if (free) begin
                m_valid <= 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("model_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("model_pending", 32'(pending), 32'(m_pending));
            checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("model_busy", 32'(busy), 32'((m_pending != 0) || m_valid));
            checkOutput("model_addr", 32'(out_addr), m_addr);
        end
    end

    // Called at a falling edge: drive inputs, then advance to the next falling edge.
    task automatic applyStimulus(input logic se, input logic [N-1:0] sv, input logic rdy, input logic clr);
        set_en    = se;
        set_vec   = sv;
        out_ready = rdy;
        clr_all   = clr;
        @(negedge clk);
    endtask

    task automatic expectBeat(input int exp_addr);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("beat_valid", 32'(out_valid), 1);
        checkOutput("beat_addr", 32'(out_addr), exp_addr);
    endtask

    initial begin
        int order_all [8] = '{2, 3, 4, 5, 6, 7, 0, 1};

        // Reset with random inputs
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_en    = 1'($urandom);
            set_vec   = N'($urandom);
            out_ready = 1'($urandom);
            clr_all   = 1'($urandom);
        end
        @(negedge clk);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_addr", 32'(out_addr), 0);
        checkOutput("rst_pending", 32'(pending), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        set_en = 1'b0; set_vec = '0; out_ready = 1'b0; clr_all = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Basic: two lanes, rr starts at 0
        applyStimulus(1'b1, 8'h24, 1'b1, 1'b0);
        checkOutput("basic_pend0", 32'(pending), 32'h24);
        checkOutput("basic_valid0", 32'(out_valid), 0);
        expectBeat(2);
        checkOutput("basic_pend1", 32'(pending), 32'h20);
        expectBeat(5);
        checkOutput("basic_pend2", 32'(pending), 0);
        checkOutput("basic_busy2", 32'(busy), 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("basic_busy_end", 32'(busy), 0);
        checkOutput("basic_valid_end", 32'(out_valid), 0);

        // Backpressure: rr=6, lanes {1,4}
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            checkOutput("bp_addr", 32'(out_addr), 1);
            checkOutput("bp_valid", 32'(out_valid), 1);
            checkOutput("bp_pending", 32'(pending), 32'h10);
        end
        expectBeat(4);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Wrap: rr=5 -> emit 6, then {1,7}, {0,1}, all lanes
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
        expectBeat(6);
        applyStimulus(1'b1, 8'h82, 1'b1, 1'b0);
        checkOutput("wrap_gap", 32'(out_valid), 0);
        expectBeat(7);
        expectBeat(1);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b0);
        expectBeat(0);
        expectBeat(1);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) expectBeat(order_all[i]);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("wrap_done", 32'(out_valid), 0);

        // Overflow: lane 5 held by backpressure, lane 3 set twice -> one emission
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h08, 1'b0, 1'b0);
        checkOutput("ovf_hold_addr", 32'(out_addr), 5);
        checkOutput("ovf_first", 32'(overflow), 0);
        applyStimulus(1'b1, 8'h08, 1'b0, 1'b0);
        checkOutput("ovf_pulse", 32'(overflow), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("ovf_clear", 32'(overflow), 0);
        expectBeat(3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("ovf_single", 32'(out_valid), 0);
        checkOutput("ovf_pend_empty", 32'(pending), 0);

        // Re-set on grant cycle: no overflow, lane 3 emitted twice
        applyStimulus(1'b1, 8'h08, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h08, 1'b1, 1'b0);
        checkOutput("reset_grant_addr", 32'(out_addr), 3);
        checkOutput("reset_grant_ovf", 32'(overflow), 0);
        checkOutput("reset_grant_pend", 32'(pending), 32'h08);
        expectBeat(3);
        checkOutput("reset_grant_ovf2", 32'(overflow), 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush beats a simultaneous set; rr returns to 0
        applyStimulus(1'b1, 8'hF0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("flush_pre_addr", 32'(out_addr), 4);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1);
        checkOutput("flush_pending", 32'(pending), 0);
        checkOutput("flush_valid", 32'(out_valid), 0);
        checkOutput("flush_addr_hold", 32'(out_addr), 4);
        checkOutput("flush_overflow", 32'(overflow), 0);
        applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
        expectBeat(0);
        expectBeat(7);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        applyStimulus(1'b1, 8'h0C, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("arst_pre_addr", 32'(out_addr), 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 0);
        checkOutput("arst_pending", 32'(pending), 0);
        checkOutput("arst_addr", 32'(out_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
        expectBeat(0);
        expectBeat(7);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("arst_done", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
